row_requester: RTL and testbench
================================

# row_requester

Initiator and receiver for the row-data request protocol. Issues sequential 32-bit request IDs on a request stream, with a bounded number of requests outstanding. Receives the framed response packets (header = request ID, BEATS_PER_PACKET data beats, footer = request ID), checks the framing, strips header and footer, and forwards the payload beats downstream. Sits on the far side of the link from the row-data server, e.g. as a host-side row fetcher or a loopback test harness.

## Interface
- BEATS_PER_PACKET, 32, data beats between header and footer (2..255)
- MAX_OUTSTANDING, 4, maximum requests issued but not yet closed by a footer (1..15)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- first_id  in  32  request ID of the first row, sampled on start
- row_count  in  32  rows to fetch, sampled on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the run completes
- hdr_err_count  out  16  header-mismatch count, saturating
- ftr_err_count  out  16  footer-mismatch count, saturating
- AXIS_RQ_TDATA / TVALID  out  32 / 1  request stream
- AXIS_RQ_TREADY  in  1
- AXIS_RX_TDATA / TVALID  in  512 / 1  response packet stream
- AXIS_RX_TREADY  out  1
- AXIS_TX_TDATA / TVALID  out  512 / 1  stripped payload stream
- AXIS_TX_TREADY  in  1

## Operation
- Reset: all outputs 0. Internal state: idle, counters 0, receive FSM in RX_HDR.
- Start when idle:
  - Latch next_id = expected_id = first_id, to_issue = rows_left = row_count, outstanding = 0, busy = 1.
  - Error counters clear at start.
  - start while busy is ignored.
- Issuer:
  - Presents AXIS_RQ_TVALID with AXIS_RQ_TDATA = next_id while to_issue > 0 and outstanding < MAX_OUTSTANDING.
  - TDATA is held stable until the handshake.
  - On handshake: next_id += 1 (mod 2^32), to_issue -= 1, outstanding += 1.
- Receive FSM:
  - RX_HDR:
    - AXIS_RX_TREADY = busy and outstanding > 0.
    - On a beat, capture hdr = TDATA[31:0]. If hdr != expected_id, increment hdr_err_count.
    - Header is not forwarded. Go to RX_DATA with beat counter = BEATS_PER_PACKET.
  - RX_DATA:
    - AXIS_RX_TREADY = !AXIS_TX_TVALID || AXIS_TX_TREADY.
    - Each accepted beat loads the TX output register; counter decrements.
    - After the last beat, go to RX_FTR.
  - RX_FTR:
    - AXIS_RX_TREADY = 1.
    - On a beat, if TDATA[31:0] != hdr, increment ftr_err_count.
    - Footer is not forwarded.
    - expected_id += 1 and outstanding -= 1. rows_left -= 1; if it reaches 0, pulse done next cycle and clear busy.
    - Return to RX_HDR.
- Simultaneous RQ handshake and footer acceptance: outstanding is unchanged.
- expected_id always advances, even after a mismatch; errors do not resynchronise framing.
- row_count = 0: done pulses one cycle after start, busy pulses for 1 cycle, no requests are issued.
- Error counters saturate at 0xFFFF.
- Reset mid-run: immediate return to reset state. A partially received packet is discarded. No done pulse.

## Timing
- start to first AXIS_RQ_TVALID: 1 cycle.
- Requests can be issued back to back, one per cycle, while credit remains.
- AXIS_RQ_TVALID/TDATA, AXIS_TX_TVALID/TDATA, done, busy and the error counters are registered outputs.
- AXIS_RX_TREADY is combinational from state and AXIS_TX_TVALID/TREADY.
- RX data beat to AXIS_TX_TVALID: 1 cycle.
- Full throughput: 1 beat per cycle with TX_TREADY held high.
- A TX stall back-pressures RX in the same cycle, with no data loss.
- Header and footer each consume exactly 1 cycle when RX_TVALID is high.
- done pulses in the cycle after the final footer handshake.

## Configuration
- ROW_TLAST_EN defined:
  - Adds output AXIS_TX_TLAST (1 bit, reset 0).
  - TLAST is asserted with the final payload beat of each packet.
- ROW_TLAST_EN undefined:
  - Port absent.
  - Behaviour otherwise identical.

## Test plan
- Basic run: first_id=0x100, row_count=3, RQ/TX ready held high, responder echoes correct packets.
  - Expect requests 0x100, 0x101, 0x102.
  - Expect 96 TX beats matching the payloads in order.
  - Expect done pulse, both error counters 0.
- Credit limit: MAX_OUTSTANDING=4, row_count=10, responder withholds all packets.
  - Expect exactly 4 requests, then RQ_TVALID low.
  - Each footer releases exactly 1 further request.
- Framing errors: row_count=2, packet 0 header 0x5, packet 1 footer mismatches its header.
  - Expect hdr_err_count=1, ftr_err_count=1.
  - Expect all 64 payload beats still forwarded, done asserted.
- Back-pressure: TX_TREADY toggles with a random 50% duty cycle.
  - Expect no lost or duplicated beats.
  - TX_TDATA stable whenever TVALID is high and TREADY is low.
- Edges:
  - row_count=0: done pulses 1 cycle after start, no RQ_TVALID.
  - first_id=0xFFFFFFFF, row_count=2: IDs 0xFFFFFFFF, 0x00000000.
  - start while busy: ignored.
  - Reset asserted mid-packet: all outputs 0; a fresh run afterwards completes cleanly.

Source files
------------

// File: rtl/row_requester.sv
// row_requester: issues sequential request IDs with bounded credit, receives framed
// response packets (header ID, BEATS_PER_PACKET data beats, footer ID), counts framing
// errors and forwards the stripped payload downstream.
// Optional feature: define ROW_TLAST_EN to add AXIS_TX_TLAST on the last payload beat.
module row_requester #(
  parameter int unsigned BEATS_PER_PACKET = 32,
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  first_id,
  input  logic [31:0]  row_count,
  output logic         busy,
  output logic         done,
  output logic [15:0]  hdr_err_count,
  output logic [15:0]  ftr_err_count,
  output logic [31:0]  AXIS_RQ_TDATA,
  output logic         AXIS_RQ_TVALID,
  input  logic         AXIS_RQ_TREADY,
  input  logic [511:0] AXIS_RX_TDATA,
  input  logic         AXIS_RX_TVALID,
  output logic         AXIS_RX_TREADY,
  output logic [511:0] AXIS_TX_TDATA,
  output logic         AXIS_TX_TVALID,
`ifdef ROW_TLAST_EN
  output logic         AXIS_TX_TLAST,
`endif
  input  logic         AXIS_TX_TREADY
);

  localparam logic [7:0] BeatsInit = 8'(BEATS_PER_PACKET);
  localparam logic [3:0] MaxOut    = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {RxHdr, RxData, RxFtr} rx_state_e;

  rx_state_e      rx_state_q, rx_state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [31:0]    next_id_q, next_id_d;
  logic [31:0]    expected_id_q, expected_id_d;
  logic [31:0]    to_issue_q, to_issue_d;
  logic [31:0]    rows_left_q, rows_left_d;
  logic [3:0]     outstanding_q, outstanding_d;
  logic           rq_valid_q, rq_valid_d;
  logic [31:0]    rq_data_q, rq_data_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]    hdr_q, hdr_d;
  logic           tx_valid_q, tx_valid_d;
  logic [511:0]   tx_data_q, tx_data_d;
  logic [15:0]    hdr_err_q, hdr_err_d;
  logic [15:0]    ftr_err_q, ftr_err_d;
`ifdef ROW_TLAST_EN
  logic           tx_last_q, tx_last_d;
`endif

  logic rq_fire, rx_fire, ftr_fire;

  assign busy           = busy_q;
  assign done           = done_q;
  assign hdr_err_count  = hdr_err_q;
  assign ftr_err_count  = ftr_err_q;
  assign AXIS_RQ_TDATA  = rq_data_q;
  assign AXIS_RQ_TVALID = rq_valid_q;
  assign AXIS_TX_TDATA  = tx_data_q;
  assign AXIS_TX_TVALID = tx_valid_q;
`ifdef ROW_TLAST_EN
  assign AXIS_TX_TLAST  = tx_last_q;
`endif

  // RX ready: headers only while a request is in flight; data follows TX back-pressure.
  always_comb begin
    AXIS_RX_TREADY = 1'b0;
    case (rx_state_q)
      RxHdr:   AXIS_RX_TREADY = busy_q && (outstanding_q != 4'd0);
      RxData:  AXIS_RX_TREADY = !tx_valid_q || AXIS_TX_TREADY;
      RxFtr:   AXIS_RX_TREADY = 1'b1;
      default: AXIS_RX_TREADY = 1'b0;
    endcase
  end

  // Next-state for issuer, receive FSM, TX register and run control.
  always_comb begin
    rx_state_d    = rx_state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    next_id_d     = next_id_q;
    expected_id_d = expected_id_q;
    to_issue_d    = to_issue_q;
    rows_left_d   = rows_left_q;
    outstanding_d = outstanding_q;
    beat_cnt_d    = beat_cnt_q;
    hdr_d         = hdr_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    hdr_err_d     = hdr_err_q;
    ftr_err_d     = ftr_err_q;
`ifdef ROW_TLAST_EN
    tx_last_d     = tx_last_q;
`endif

    rq_fire  = rq_valid_q && AXIS_RQ_TREADY;
    rx_fire  = AXIS_RX_TVALID && AXIS_RX_TREADY;
    ftr_fire = rx_fire && (rx_state_q == RxFtr);

    if (rq_fire) begin
      next_id_d  = next_id_q + 32'd1;
      to_issue_d = to_issue_q - 32'd1;
    end

    // Issue and footer in the same cycle cancel out.
    if (rq_fire && !ftr_fire) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!rq_fire && ftr_fire) begin
      outstanding_d = outstanding_q - 4'd1;
    end

    // TX register drains on handshake unless refilled by a payload beat below.
    if (tx_valid_q && AXIS_TX_TREADY) begin
      tx_valid_d = 1'b0;
    end

    case (rx_state_q)
      RxHdr: begin
        if (rx_fire) begin
          hdr_d = AXIS_RX_TDATA[31:0];
          if (AXIS_RX_TDATA[31:0] != expected_id_q && hdr_err_q != 16'hFFFF) begin
            hdr_err_d = hdr_err_q + 16'd1;
          end
          beat_cnt_d = BeatsInit;
          rx_state_d = RxData;
        end
      end
      RxData: begin
        if (rx_fire) begin
          tx_valid_d = 1'b1;
          tx_data_d  = AXIS_RX_TDATA;
`ifdef ROW_TLAST_EN
          tx_last_d  = (beat_cnt_q == 8'd1);
`endif
          beat_cnt_d = beat_cnt_q - 8'd1;
          if (beat_cnt_q == 8'd1) begin
            rx_state_d = RxFtr;
          end
        end
      end
      RxFtr: begin
        if (rx_fire) begin
          if (AXIS_RX_TDATA[31:0] != hdr_q && ftr_err_q != 16'hFFFF) begin
            ftr_err_d = ftr_err_q + 16'd1;
          end
          // Framing is never resynchronised: the expected ID always advances.
          expected_id_d = expected_id_q + 32'd1;
          rows_left_d   = rows_left_q - 32'd1;
          if (rows_left_q == 32'd1) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
          rx_state_d = RxHdr;
        end
      end
      default: rx_state_d = RxHdr;
    endcase

    // A zero-row run holds busy for exactly one cycle.
    if (busy_q && rows_left_q == 32'd0) begin
      busy_d = 1'b0;
    end

    if (start && !busy_q) begin
      next_id_d     = first_id;
      expected_id_d = first_id;
      to_issue_d    = row_count;
      rows_left_d   = row_count;
      outstanding_d = 4'd0;
      busy_d        = 1'b1;
      done_d        = (row_count == 32'd0);
      hdr_err_d     = 16'd0;
      ftr_err_d     = 16'd0;
    end

    // Request outputs registered from next state; data only moves on a handshake.
    rq_valid_d = busy_d && (to_issue_d != 32'd0) && (outstanding_d < MaxOut);
    rq_data_d  = next_id_d;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q    <= RxHdr;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      next_id_q     <= 32'd0;
      expected_id_q <= 32'd0;
      to_issue_q    <= 32'd0;
      rows_left_q   <= 32'd0;
      outstanding_q <= 4'd0;
      rq_valid_q    <= 1'b0;
      rq_data_q     <= 32'd0;
      beat_cnt_q    <= 8'd0;
      hdr_q         <= 32'd0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 512'd0;
      hdr_err_q     <= 16'd0;
      ftr_err_q     <= 16'd0;
`ifdef ROW_TLAST_EN
      tx_last_q     <= 1'b0;
`endif
    end else begin
      rx_state_q    <= rx_state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      next_id_q     <= next_id_d;
      expected_id_q <= expected_id_d;
      to_issue_q    <= to_issue_d;
      rows_left_q   <= rows_left_d;
      outstanding_q <= outstanding_d;
      rq_valid_q    <= rq_valid_d;
      rq_data_q     <= rq_data_d;
      beat_cnt_q    <= beat_cnt_d;
      hdr_q         <= hdr_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      hdr_err_q     <= hdr_err_d;
      ftr_err_q     <= ftr_err_d;
`ifdef ROW_TLAST_EN
      tx_last_q     <= tx_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_row_requester.sv
// Bench for row_requester: a responder echoes framed packets for each issued request,
// expected payload beats are queued as they are driven and compared against TX output.
module tb_row_requester;
  localparam int BEATS = 32;
  localparam int MAXO  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  first_id = 32'd0;
  logic [31:0]  row_count = 32'd0;
  logic         busy, done;
  logic [15:0]  hdr_err_count, ftr_err_count;
  logic [31:0]  AXIS_RQ_TDATA;
  logic         AXIS_RQ_TVALID;
  logic         AXIS_RQ_TREADY = 1'b1;
  logic [511:0] AXIS_RX_TDATA = '0;
  logic         AXIS_RX_TVALID = 1'b0;
  logic         AXIS_RX_TREADY;
  logic [511:0] AXIS_TX_TDATA;
  logic         AXIS_TX_TVALID;
  logic         AXIS_TX_TREADY = 1'b1;
`ifdef ROW_TLAST_EN
  logic         AXIS_TX_TLAST;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int stab_viol = 0;
  int tlast_cnt = 0;
  bit prev_stall = 1'b0;
  logic [511:0] prev_data = '0;
  bit bp_stop = 1'b0;

  logic [31:0]  rq_obs[$];
  logic [31:0]  req_pend[$];
  logic [511:0] tx_obs[$];
  logic [511:0] tx_exp[$];

  row_requester #(.BEATS_PER_PACKET(BEATS), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .start(start), .first_id(first_id), .row_count(row_count),
    .busy(busy), .done(done), .hdr_err_count(hdr_err_count), .ftr_err_count(ftr_err_count),
    .AXIS_RQ_TDATA(AXIS_RQ_TDATA), .AXIS_RQ_TVALID(AXIS_RQ_TVALID),
    .AXIS_RQ_TREADY(AXIS_RQ_TREADY),
    .AXIS_RX_TDATA(AXIS_RX_TDATA), .AXIS_RX_TVALID(AXIS_RX_TVALID),
    .AXIS_RX_TREADY(AXIS_RX_TREADY),
    .AXIS_TX_TDATA(AXIS_TX_TDATA), .AXIS_TX_TVALID(AXIS_TX_TVALID),
`ifdef ROW_TLAST_EN
    .AXIS_TX_TLAST(AXIS_TX_TLAST),
`endif
    .AXIS_TX_TREADY(AXIS_TX_TREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want $finish before 50000 cycles");
    $fatal(1);
  end

  // Monitor on the falling edge: records handshakes, done pulses and TX stall stability.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!AXIS_TX_TVALID || AXIS_TX_TDATA !== prev_data)) begin
        stab_viol <= stab_viol + 1;
      end
      prev_stall <= AXIS_TX_TVALID && !AXIS_TX_TREADY;
      prev_data  <= AXIS_TX_TDATA;
      if (AXIS_TX_TVALID && AXIS_TX_TREADY) tx_obs.push_back(AXIS_TX_TDATA);
      if (AXIS_RQ_TVALID && AXIS_RQ_TREADY) begin
        rq_obs.push_back(AXIS_RQ_TDATA);
        req_pend.push_back(AXIS_RQ_TDATA);
      end
      if (done) done_cnt <= done_cnt + 1;
`ifdef ROW_TLAST_EN
      if (AXIS_TX_TVALID && AXIS_TX_TREADY && AXIS_TX_TLAST) tlast_cnt <= tlast_cnt + 1;
`endif
    end
  end

  function automatic logic [511:0] rand_beat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_sb();
    rq_obs.delete();
    req_pend.delete();
    tx_obs.delete();
    tx_exp.delete();
  endtask

  task automatic do_start(input logic [31:0] fid, input logic [31:0] cnt);
    first_id  = fid;
    row_count = cnt;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic send_beat(input logic [511:0] d);
    bit ok;
    ok = 1'b0;
    AXIS_RX_TDATA  = d;
    AXIS_RX_TVALID = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (AXIS_RX_TREADY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    AXIS_RX_TVALID = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rx_handshake got no TREADY want TREADY within 400 cycles");
    end
  endtask

  task automatic send_packet(input logic [31:0] hv, input logic [31:0] fv);
    logic [511:0] d;
    send_beat({480'd0, hv});
    for (int b = 0; b < BEATS; b++) begin
      d = rand_beat();
      tx_exp.push_back(d);
      send_beat(d);
    end
    send_beat({480'd0, fv});
  endtask

  task automatic respond(input int n, input int hdr_bad, input int ftr_bad);
    logic [31:0] id, hv, fv;
    int w;
    for (int p = 0; p < n; p++) begin
      w = 0;
      while (req_pend.size() == 0 && w < 500) begin
        tick(1);
        w++;
      end
      n_cmp++;
      if (req_pend.size() == 0) begin
        n_fail++;
        $display("FAIL respond_wait got no request want request for packet %0d", p);
        return;
      end
      id = req_pend.pop_front();
      hv = (p == hdr_bad) ? 32'h5 : id;
      fv = (p == ftr_bad) ? ~hv : hv;
      send_packet(hv, fv);
    end
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++;
    if ({busy, done, AXIS_RQ_TVALID, AXIS_RX_TREADY, AXIS_TX_TVALID} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000",
               {busy, done, AXIS_RQ_TVALID, AXIS_RX_TREADY, AXIS_TX_TVALID});
    end
    n_cmp++;
    if ({hdr_err_count, ftr_err_count, AXIS_RQ_TDATA} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_counts got %h want 0", {hdr_err_count, ftr_err_count, AXIS_RQ_TDATA});
    end
    n_cmp++;
    if (AXIS_TX_TDATA !== 512'd0) begin
      n_fail++;
      $display("FAIL reset_txdata got %h want 0", AXIS_TX_TDATA);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int base, tl_base;
    bit ok;
    clear_sb();
    base = done_cnt;
    tl_base = tlast_cnt;
    do_start(32'h100, 32'd3);
    n_cmp++;
    if (AXIS_RQ_TVALID !== 1'b1 || AXIS_RQ_TDATA !== 32'h100) begin
      n_fail++;
      $display("FAIL basic_first_rq got v=%b d=%h want v=1 d=00000100",
               AXIS_RQ_TVALID, AXIS_RQ_TDATA);
    end
    respond(3, -1, -1);
    wait_done(base, ok);
    tick(3);
    n_cmp++;
    if (!ok || done_cnt != base + 1) begin
      n_fail++;
      $display("FAIL basic_done got %0d pulses want 1", done_cnt - base);
    end
    n_cmp++;
    if (rq_obs.size() != 3) begin
      n_fail++;
      $display("FAIL basic_rq_count got %0d want 3", rq_obs.size());
    end
    for (int i = 0; i < rq_obs.size() && i < 3; i++) begin
      n_cmp++;
      if (rq_obs[i] !== 32'h100 + 32'(i)) begin
        n_fail++;
        $display("FAIL basic_rq[%0d] got %h want %h", i, rq_obs[i], 32'h100 + 32'(i));
      end
    end
    n_cmp++;
    if (tx_obs.size() != 96 || tx_exp.size() != 96) begin
      n_fail++;
      $display("FAIL basic_tx_count got %0d want 96", tx_obs.size());
    end
    for (int i = 0; i < tx_obs.size() && i < tx_exp.size(); i++) begin
      n_cmp++;
      if (tx_obs[i] !== tx_exp[i]) begin
        n_fail++;
        $display("FAIL basic_tx[%0d] got %h want %h", i, tx_obs[i], tx_exp[i]);
      end
    end
    n_cmp++;
    if ({busy, hdr_err_count, ftr_err_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL basic_end got busy=%b hdr=%0d ftr=%0d want 0 0 0",
               busy, hdr_err_count, ftr_err_count);
    end
`ifdef ROW_TLAST_EN
    n_cmp++;
    if (tlast_cnt != tl_base + 3) begin
      n_fail++;
      $display("FAIL basic_tlast got %0d want 3", tlast_cnt - tl_base);
    end
`endif
  endtask

  task automatic test_credit();
    int base, want;
    bit ok;
    logic [31:0] id;
    clear_sb();
    base = done_cnt;
    do_start(32'h200, 32'd10);
    tick(20);
    n_cmp++;
    if (rq_obs.size() != MAXO || AXIS_RQ_TVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_hold got %0d reqs v=%b want %0d reqs v=0",
               rq_obs.size(), AXIS_RQ_TVALID, MAXO);
    end
    for (int k = 1; k <= 10; k++) begin
      if (req_pend.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL credit_pend got 0 requests want 1 before packet %0d", k);
        break;
      end
      id = req_pend.pop_front();
      send_packet(id, id);
      tick(4);
      want = (MAXO + k > 10) ? 10 : MAXO + k;
      n_cmp++;
      if (rq_obs.size() != want) begin
        n_fail++;
        $display("FAIL credit_release[%0d] got %0d want %0d", k, rq_obs.size(), want);
      end
    end
    wait_done(base, ok);
    tick(3);
    n_cmp++;
    if (!ok || done_cnt != base + 1) begin
      n_fail++;
      $display("FAIL credit_done got %0d pulses want 1", done_cnt - base);
    end
    for (int i = 0; i < rq_obs.size(); i++) begin
      n_cmp++;
      if (rq_obs[i] !== 32'h200 + 32'(i)) begin
        n_fail++;
        $display("FAIL credit_rq[%0d] got %h want %h", i, rq_obs[i], 32'h200 + 32'(i));
      end
    end
    n_cmp++;
    if (tx_obs.size() != tx_exp.size() || tx_obs.size() != 320) begin
      n_fail++;
      $display("FAIL credit_tx_count got %0d want 320", tx_obs.size());
    end
  endtask

  task automatic test_framing();
    int base;
    bit ok;
    clear_sb();
    base = done_cnt;
    do_start(32'h300, 32'd2);
    respond(2, 0, 1);
    wait_done(base, ok);
    tick(3);
    n_cmp++;
    if (!ok || done_cnt != base + 1) begin
      n_fail++;
      $display("FAIL framing_done got %0d pulses want 1", done_cnt - base);
    end
    n_cmp++;
    if (hdr_err_count !== 16'd1 || ftr_err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL framing_errs got hdr=%0d ftr=%0d want 1 1", hdr_err_count, ftr_err_count);
    end
    n_cmp++;
    if (tx_obs.size() != 64 || tx_exp.size() != 64) begin
      n_fail++;
      $display("FAIL framing_tx_count got %0d want 64", tx_obs.size());
    end
    for (int i = 0; i < tx_obs.size() && i < tx_exp.size(); i++) begin
      n_cmp++;
      if (tx_obs[i] !== tx_exp[i]) begin
        n_fail++;
        $display("FAIL framing_tx[%0d] got %h want %h", i, tx_obs[i], tx_exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, sv_base;
    bit ok;
    clear_sb();
    base = done_cnt;
    sv_base = stab_viol;
    bp_stop = 1'b0;
    ok = 1'b0;
    fork
      begin
        while (!bp_stop) begin
          AXIS_TX_TREADY = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
      begin
        do_start(32'h400, 32'd4);
        respond(4, -1, -1);
        wait_done(base, ok);
        bp_stop = 1'b1;
      end
    join
    AXIS_TX_TREADY = 1'b1;
    tick(5);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_done got no done want done");
    end
    n_cmp++;
    if (tx_obs.size() != 128 || tx_exp.size() != 128) begin
      n_fail++;
      $display("FAIL bp_tx_count got %0d want 128", tx_obs.size());
    end
    for (int i = 0; i < tx_obs.size() && i < tx_exp.size(); i++) begin
      n_cmp++;
      if (tx_obs[i] !== tx_exp[i]) begin
        n_fail++;
        $display("FAIL bp_tx[%0d] got %h want %h", i, tx_obs[i], tx_exp[i]);
      end
    end
    n_cmp++;
    if (stab_viol != sv_base) begin
      n_fail++;
      $display("FAIL bp_stable got %0d violations want 0", stab_viol - sv_base);
    end
  endtask

  task automatic test_zero_rows();
    clear_sb();
    do_start(32'h500, 32'd0);
    n_cmp++;
    if ({done, busy, AXIS_RQ_TVALID} !== 3'b110) begin
      n_fail++;
      $display("FAIL zero_pulse got done,busy,rqv=%b want 110", {done, busy, AXIS_RQ_TVALID});
    end
    tick(1);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_after got done,busy=%b want 00", {done, busy});
    end
    tick(5);
    n_cmp++;
    if (rq_obs.size() != 0) begin
      n_fail++;
      $display("FAIL zero_rq got %0d requests want 0", rq_obs.size());
    end
  endtask

  task automatic test_id_wrap();
    int base;
    bit ok;
    clear_sb();
    base = done_cnt;
    do_start(32'hFFFF_FFFF, 32'd2);
    respond(2, -1, -1);
    wait_done(base, ok);
    tick(3);
    n_cmp++;
    if (!ok || rq_obs.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_count got %0d requests want 2", rq_obs.size());
    end else begin
      n_cmp++;
      if (rq_obs[0] !== 32'hFFFF_FFFF || rq_obs[1] !== 32'h0) begin
        n_fail++;
        $display("FAIL wrap_ids got %h %h want ffffffff 00000000", rq_obs[0], rq_obs[1]);
      end
    end
    n_cmp++;
    if (hdr_err_count !== 16'd0 || ftr_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_errs got hdr=%0d ftr=%0d want 0 0", hdr_err_count, ftr_err_count);
    end
  endtask

  task automatic test_start_busy();
    int base;
    bit ok;
    clear_sb();
    base = done_cnt;
    do_start(32'h600, 32'd2);
    tick(2);
    do_start(32'h700, 32'd5);
    respond(2, -1, -1);
    wait_done(base, ok);
    tick(10);
    n_cmp++;
    if (!ok || done_cnt != base + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_done got %0d pulses busy=%b want 1 0", done_cnt - base, busy);
    end
    n_cmp++;
    if (rq_obs.size() != 2) begin
      n_fail++;
      $display("FAIL busy_start_count got %0d want 2", rq_obs.size());
    end else begin
      n_cmp++;
      if (rq_obs[0] !== 32'h600 || rq_obs[1] !== 32'h601) begin
        n_fail++;
        $display("FAIL busy_start_ids got %h %h want 00000600 00000601", rq_obs[0], rq_obs[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    logic [31:0] id;
    clear_sb();
    base = done_cnt;
    do_start(32'h800, 32'd2);
    tick(3);
    id = (req_pend.size() != 0) ? req_pend.pop_front() : 32'h800;
    send_beat({480'd0, id});
    for (int b = 0; b < 5; b++) send_beat(rand_beat());
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if ({busy, done, AXIS_RQ_TVALID, AXIS_RX_TREADY, AXIS_TX_TVALID} !== 5'b0 ||
        {hdr_err_count, ftr_err_count, AXIS_RQ_TDATA} !== 64'd0 || AXIS_TX_TDATA !== 512'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got ctrl=%b rqd=%h want all 0",
               {busy, done, AXIS_RQ_TVALID, AXIS_RX_TREADY, AXIS_TX_TVALID}, AXIS_RQ_TDATA);
    end
    reset = 1'b0;
    tick(2);
    n_cmp++;
    if (done_cnt != base) begin
      n_fail++;
      $display("FAIL midreset_nodone got %0d pulses want 0", done_cnt - base);
    end
    clear_sb();
    do_start(32'h900, 32'd2);
    respond(2, -1, -1);
    wait_done(base, ok);
    tick(3);
    n_cmp++;
    if (!ok || rq_obs.size() != 2 || hdr_err_count !== 16'd0 || ftr_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_rerun got reqs=%0d hdr=%0d ftr=%0d want 2 0 0",
               rq_obs.size(), hdr_err_count, ftr_err_count);
    end
    n_cmp++;
    if (tx_obs.size() != 64 || tx_exp.size() != 64) begin
      n_fail++;
      $display("FAIL midreset_tx_count got %0d want 64", tx_obs.size());
    end
    for (int i = 0; i < tx_obs.size() && i < tx_exp.size(); i++) begin
      n_cmp++;
      if (tx_obs[i] !== tx_exp[i]) begin
        n_fail++;
        $display("FAIL midreset_tx[%0d] got %h want %h", i, tx_obs[i], tx_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_framing();
    test_backpressure();
    test_zero_rows();
    test_id_wrap();
    test_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
